// File: rtl/minority_tester_if.sv
// Signal bundle between the minority-gate tester and the gate under test / operator.
// master: tester side (takes start and y, drives the gate inputs and the result flags).
// slave : environment side (drives start and y, observes gate inputs and results).
interface minority_tester_if;
   logic       start;       // begin a run (honoured only when the tester is idle or done)
   logic       y;           // output of the gate under test
   logic       a;           // gate input a (vector bit 2)
   logic       b;           // gate input b (vector bit 1)
   logic       c;           // gate input c (vector bit 0)
   logic       busy;        // run in progress
   logic       done;        // run finished, results valid
   logic       pass;        // no vector failed (valid with done)
   logic [3:0] err_count;   // number of failing vectors, 0..8
   logic [7:0] err_vec;     // bit i set when vector i failed
   logic [2:0] first_fail;  // lowest failing vector, 0 when none failed

   modport master (
      input  start, y,
      output a, b, c, busy, done, pass, err_count, err_vec, first_fail
   );

   modport slave (
      output start, y,
      input  a, b, c, busy, done, pass, err_count, err_vec, first_fail
   );
endinterface

// File: rtl/minority_tester.sv
// On-board tester: steps a 3-input minority gate through vectors 0..7, samples y after a settle time.
// Ports: clk/reset (async, active-high) plain; everything else via minority_tester_if.master.
// Latency: start edge to done is 8*(SETTLE_CYCLES+1) edges; start is ignored while a run is busy.
module minority_tester #(
   parameter int unsigned SETTLE_CYCLES = 4   // cycles each vector is held before y is sampled, 1..255
) (
   input  logic              clk,
   input  logic              reset,
   minority_tester_if.master bus
);

   typedef enum logic [1:0] {S_IDLE, S_APPLY, S_CHECK, S_DONE} state_t;

   // Expected minority output indexed by the vector {a,b,c}.
   localparam logic [7:0] EXP_MAP  = 8'b0001_0111;
   localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);

   state_t     r_state;
   state_t     w_state_nxt;

   logic [2:0] r_vec;
   logic [7:0] r_cnt;
   logic       r_busy;
   logic       r_done;
   logic       r_pass;
   logic [3:0] r_err_count;
   logic [7:0] r_err_vec;
   logic [2:0] r_first_fail;

   logic       w_launch;    // start accepted this edge
   logic       w_check;     // this edge samples y
   logic       w_finish;    // this edge checks the last vector
   logic       w_mismatch;

   // y is compared with !== so an undriven or X gate counts as a failure in simulation.
   assign w_mismatch = (bus.y !== EXP_MAP[r_vec]);

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE,
         S_DONE:  if (bus.start) w_state_nxt = S_APPLY;
         S_APPLY: if (r_cnt == CNT_LAST) w_state_nxt = S_CHECK;
         S_CHECK: w_state_nxt = (r_vec == 3'd7) ? S_DONE : S_APPLY;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Output/control decode
   always_comb begin
      w_launch = 1'b0;
      w_check  = 1'b0;
      w_finish = 1'b0;
      case (r_state)
         S_IDLE,
         S_DONE:  w_launch = bus.start;
         S_CHECK: begin
            w_check  = 1'b1;
            w_finish = (r_vec == 3'd7);
         end
         default: ;
      endcase
   end

   // Registered datapath and result flags
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_vec        <= 3'd0;
         r_cnt        <= 8'd0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_pass       <= 1'b0;
         r_err_count  <= 4'd0;
         r_err_vec    <= 8'd0;
         r_first_fail <= 3'd0;
      end else if (w_launch) begin
         r_vec        <= 3'd0;
         r_cnt        <= 8'd0;
         r_busy       <= 1'b1;
         r_done       <= 1'b0;
         r_pass       <= 1'b0;
         r_err_count  <= 4'd0;
         r_err_vec    <= 8'd0;
         r_first_fail <= 3'd0;
      end else if (r_state == S_APPLY) begin
         r_cnt <= r_cnt + 8'd1;
      end else if (w_check) begin
         if (w_mismatch) begin
            r_err_vec[r_vec] <= 1'b1;
            r_err_count      <= r_err_count + 4'd1;
            if (r_err_count == 4'd0) begin
               r_first_fail <= r_vec;
            end
         end
         if (w_finish) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
            // Includes the verdict on vector 7, which lands on this same edge.
            r_pass <= (r_err_count == 4'd0) && !w_mismatch;
         end else begin
            r_vec <= r_vec + 3'd1;
            r_cnt <= 8'd0;
         end
      end
   end

   assign bus.a          = r_vec[2];
   assign bus.b          = r_vec[1];
   assign bus.c          = r_vec[0];
   assign bus.busy       = r_busy;
   assign bus.done       = r_done;
   assign bus.pass       = r_pass;
   assign bus.err_count  = r_err_count;
   assign bus.err_vec    = r_err_vec;
   assign bus.first_fail = r_first_fail;

endmodule

// File: tb/tb_minority_tester.sv
// Bench for minority_tester: behavioural gate models drive y, results are checked against a scoreboard.
// dut0 uses the default settle time, dut1 uses SETTLE_CYCLES=1 for vector sequencing.
// Prints one summary line at the end.
module tb_minority_tester;

   logic clk = 1'b0;
   logic reset;
   int   mode0;          // 0 minority, 1 tied 0, 2 majority, 3 tied 1
   int   total = 0;
   int   bad   = 0;

   logic [15:0] sb_q[$];  // expected {err_count, err_vec, first_fail, pass} per run
   logic [2:0]  vec_q[$]; // expected {a,b,c} per cycle on dut1

   always #5 clk = ~clk;

   minority_tester_if if0 ();
   minority_tester_if if1 ();

   minority_tester #(.SETTLE_CYCLES(4)) dut0 (.clk(clk), .reset(reset), .bus(if0.master));
   minority_tester #(.SETTLE_CYCLES(1)) dut1 (.clk(clk), .reset(reset), .bus(if1.master));

   function automatic logic gate_out(input int mode, input logic [2:0] v);
      int ones;
      ones = int'(v[0]) + int'(v[1]) + int'(v[2]);
      case (mode)
         0:       return (ones < 2);
         1:       return 1'b0;
         2:       return (ones >= 2);
         default: return 1'b1;
      endcase
   endfunction

   assign if0.y = gate_out(mode0, {if0.a, if0.b, if0.c});
   assign if1.y = gate_out(0, {if1.a, if1.b, if1.c});

   function automatic logic [15:0] model_res(input int mode);
      logic [3:0] cnt;
      logic [7:0] ev;
      logic [2:0] ff;
      logic [2:0] vv;
      logic       mino;
      cnt = 4'd0;
      ev  = 8'd0;
      ff  = 3'd0;
      for (int v = 0; v < 8; v++) begin
         vv   = 3'(v);
         mino = (int'(vv[0]) + int'(vv[1]) + int'(vv[2])) <= 1;
         if (gate_out(mode, vv) != mino) begin
            ev[v] = 1'b1;
            if (cnt == 4'd0) ff = vv;
            cnt = cnt + 4'd1;
         end
      end
      return {cnt, ev, ff, (cnt == 4'd0)};
   endfunction

   function automatic logic [15:0] res0();
      return {if0.err_count, if0.err_vec, if0.first_fail, if0.pass};
   endfunction

   function automatic logic [20:0] outs0();
      return {if0.a, if0.b, if0.c, if0.busy, if0.done, if0.pass,
              if0.err_count, if0.err_vec, if0.first_fail};
   endfunction

   function automatic logic [20:0] outs1();
      return {if1.a, if1.b, if1.c, if1.busy, if1.done, if1.pass,
              if1.err_count, if1.err_vec, if1.first_fail};
   endfunction

   task automatic pulse_start(input int which);
      @(negedge clk);
      if (which == 0) if0.start = 1'b1; else if1.start = 1'b1;
      @(posedge clk);
      #1;
      if0.start = 1'b0;
      if1.start = 1'b0;
   endtask

   // Counts edges after the start edge until done is seen; 200 means it never came.
   task automatic wait_done(input int which, output int edges);
      edges = 0;
      while (edges < 200) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
         if ((which == 0) ? if0.done : if1.done) break;
      end
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      if0.start = 1'b0;
      if1.start = 1'b0;
      mode0     = 0;
      repeat (2) @(negedge clk);
      total++;
      if (outs0() !== 21'd0) begin
         bad++;
         $display("FAIL reset_outs0 got=%h exp=0", outs0());
      end
      total++;
      if (outs1() !== 21'd0) begin
         bad++;
         $display("FAIL reset_outs1 got=%h exp=0", outs1());
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   // Correct gate, stuck-at-0, majority; each run starts from DONE of the previous one.
   task automatic test_gate_models();
      int          edges;
      logic [15:0] exp_r;
      for (int m = 0; m < 3; m++) begin
         mode0 = m;
         sb_q.push_back(model_res(m));
         pulse_start(0);
         wait_done(0, edges);
         total++;
         if (edges !== 40) begin
            bad++;
            $display("FAIL latency_mode%0d got=%0d exp=40", m, edges);
         end
         exp_r = sb_q.pop_front();
         total++;
         if (res0() !== exp_r) begin
            bad++;
            $display("FAIL result_mode%0d got=%h exp=%h", m, res0(), exp_r);
         end
      end
   endtask

   task automatic test_settle1();
      logic [2:0] e;
      for (int v = 0; v < 8; v++) begin
         vec_q.push_back(3'(v));
         vec_q.push_back(3'(v));
      end
      pulse_start(1);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         e = vec_q.pop_front();
         total++;
         if ({if1.done, if1.a, if1.b, if1.c} !== {1'b0, e}) begin
            bad++;
            $display("FAIL settle1_cycle%0d got done,abc=%b exp=%b", i,
                     {if1.done, if1.a, if1.b, if1.c}, {1'b0, e});
         end
      end
      @(negedge clk);
      total++;
      if ({if1.done, if1.pass, if1.a, if1.b, if1.c} !== 5'b11111) begin
         bad++;
         $display("FAIL settle1_done got=%b exp=11111", {if1.done, if1.pass, if1.a, if1.b, if1.c});
      end
   endtask

   task automatic test_midrun_start();
      int          edges;
      bit          pulsed;
      logic [15:0] exp_r;
      mode0 = 0;
      sb_q.push_back(model_res(0));
      pulse_start(0);
      edges  = 0;
      pulsed = 0;
      while (edges < 200) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
         if0.start = 1'b0;
         if (if0.done) break;
         if (!pulsed && {if0.a, if0.b, if0.c} == 3'd3) begin
            if0.start = 1'b1;
            pulsed    = 1;
         end
      end
      total++;
      if (edges !== 40) begin
         bad++;
         $display("FAIL midrun_latency got=%0d exp=40", edges);
      end
      exp_r = sb_q.pop_front();
      total++;
      if (res0() !== exp_r) begin
         bad++;
         $display("FAIL midrun_result got=%h exp=%h", res0(), exp_r);
      end
      // Second run with y tied high, started from DONE.
      mode0 = 3;
      sb_q.push_back(model_res(3));
      pulse_start(0);
      @(negedge clk);
      total++;
      if ({if0.done, if0.busy, if0.pass} !== 3'b010) begin
         bad++;
         $display("FAIL restart_flags got done,busy,pass=%b exp=010", {if0.done, if0.busy, if0.pass});
      end
      wait_done(0, edges);
      total++;
      if (edges !== 40) begin
         bad++;
         $display("FAIL tied1_latency got=%0d exp=40", edges);
      end
      exp_r = sb_q.pop_front();
      total++;
      if (res0() !== exp_r) begin
         bad++;
         $display("FAIL tied1_result got=%h exp=%h", res0(), exp_r);
      end
   endtask

   task automatic test_reset_midrun();
      int          k;
      int          edges;
      logic [15:0] exp_r;
      mode0 = 1;
      pulse_start(0);
      k = 0;
      while (k < 200 && {if0.a, if0.b, if0.c} !== 3'd5) begin
         @(negedge clk);
         k++;
      end
      total++;
      if (k >= 200 || if0.err_count !== 4'd4) begin
         bad++;
         $display("FAIL vec5_err_count got=%0d exp=4 (waited %0d)", if0.err_count, k);
      end
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      total++;
      if (outs0() !== 21'd0) begin
         bad++;
         $display("FAIL async_reset_outs got=%h exp=0", outs0());
      end
      @(negedge clk);
      reset = 1'b0;
      mode0 = 0;
      sb_q.push_back(model_res(0));
      pulse_start(0);
      wait_done(0, edges);
      total++;
      if (edges !== 40) begin
         bad++;
         $display("FAIL post_reset_latency got=%0d exp=40", edges);
      end
      exp_r = sb_q.pop_front();
      total++;
      if (res0() !== exp_r) begin
         bad++;
         $display("FAIL post_reset_result got=%h exp=%h", res0(), exp_r);
      end
   endtask

   initial begin
      test_reset();
      test_gate_models();
      test_settle1();
      test_midrun_start();
      test_reset_midrun();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
